// File: rtl/vga_burst_reader.sv
// Avalon burst-read host that streams the framebuffer into a pixel FIFO with a registered head.
// Define VGA_READER_STATS_EN to add the underflow_cnt and frame_cnt statistics outputs.
module vga_burst_reader #(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter int unsigned BURST      = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [5:0]  avm_burstcount,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic        frame_start,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        underflow
`ifdef VGA_READER_STATS_EN
  ,
  output logic [15:0] underflow_cnt,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned   AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned   NumBursts  = (HDISP * VDISP) / BURST;
  localparam int unsigned   BW         = (NumBursts > 1) ? $clog2(NumBursts) : 1;
  localparam logic [31:0]   BurstBytes = 32'(4 * BURST);
  localparam logic [AW:0]   OccLimit   = (AW + 1)'(FIFO_DEPTH - BURST);
  localparam logic [BW-1:0] LastBurst  = BW'(NumBursts - 1);
  localparam logic [4:0]    LastBeat   = 5'(BURST - 1);

  typedef enum logic [1:0] {StIdle, StReq, StData} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [4:0]      beat_q, beat_d;
  logic            flush_pend_q, flush_pend_d;

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q, occ;
  logic            out_valid_q;
  logic [31:0]     out_data_q;
  logic            underflow_q;
  logic            push, pop, load, flush, wrap;

  // Occupancy includes the word parked in the output register.
  assign occ  = cnt_q + (AW + 1)'(out_valid_q);
  assign pop  = out_valid_q & pix_ready;
  assign load = (cnt_q != '0) & (~out_valid_q | pop);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    flush        = 1'b0;
    wrap         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          flush   = 1'b1;
          addr_d  = BASE_ADDR;
          burst_d = '0;
        end else if (occ <= OccLimit && !flush_pend_q) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // Once waitrequest is low the burst is committed, so frame_start must drain it.
        if (!avm_waitrequest) begin
          state_d = StData;
          beat_d  = '0;
          if (frame_start) begin
            flush        = 1'b1;
            flush_pend_d = 1'b1;
          end
        end else if (frame_start) begin
          flush   = 1'b1;
          addr_d  = BASE_ADDR;
          burst_d = '0;
          state_d = StIdle;
        end
      end
      StData: begin
        if (frame_start) begin
          flush        = 1'b1;
          flush_pend_d = 1'b1;
        end
        if (avm_readdatavalid) begin
          beat_d = beat_q + 5'd1;
          push   = !frame_start && !flush_pend_q;
          if (beat_q == LastBeat) begin
            state_d = StIdle;
            if (frame_start || flush_pend_q) begin
              flush        = 1'b1;
              flush_pend_d = 1'b0;
              addr_d       = BASE_ADDR;
              burst_d      = '0;
            end else if (burst_q == LastBurst) begin
              wrap    = 1'b1;
              addr_d  = BASE_ADDR;
              burst_d = '0;
            end else begin
              addr_d  = addr_q + BurstBytes;
              burst_d = burst_q + BW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= BASE_ADDR;
      burst_q      <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= avm_readdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (flush) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (load) begin
        out_data_q  <= mem_q[rptr_q];
        out_valid_q <= 1'b1;
        rptr_q      <= rptr_q + AW'(1);
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
      cnt_q <= cnt_q + (AW + 1)'(push) - (AW + 1)'(load);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q <= 1'b0;
    end else if (pix_ready && !out_valid_q) begin
      underflow_q <= 1'b1;
    end
  end

`ifdef VGA_READER_STATS_EN
  logic [15:0] underflow_cnt_q, frame_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_cnt_q <= '0;
      frame_cnt_q     <= '0;
    end else begin
      if (pix_ready && !out_valid_q && underflow_cnt_q != 16'hFFFF) begin
        underflow_cnt_q <= underflow_cnt_q + 16'd1;
      end
      if (frame_start || wrap) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign underflow_cnt = underflow_cnt_q;
  assign frame_cnt     = frame_cnt_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && !load && cnt_q == (AW + 1)'(FIFO_DEPTH)))
        else $error("pixel FIFO overflow");
    end
  end
`endif

  assign avm_address    = addr_q;
  assign avm_read       = (state_q == StReq);
  assign avm_burstcount = 6'(BURST);
  assign avm_byteenable = 4'hF;
  assign pix_data       = out_data_q;
  assign pix_valid      = out_valid_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_vga_burst_reader.sv
// Directed-plus-random bench for vga_burst_reader: an Avalon agent model serves bursts and
// every popped pixel is checked against the word the frame holds at that linear position.
module tb_vga_burst_reader;

  localparam int unsigned HDISP        = 16;
  localparam int unsigned VDISP        = 8;
  localparam int unsigned BURST        = 16;
  localparam int unsigned FIFO_DEPTH   = 64;
  localparam logic [31:0] BASE         = 32'h0;
  localparam int unsigned FRAME_WORDS  = HDISP * VDISP;
  localparam int unsigned FRAME_BURSTS = FRAME_WORDS / BURST;

  logic        clk;
  logic        reset_n;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [5:0]  avm_burstcount;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic        frame_start;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        underflow;
`ifdef VGA_READER_STATS_EN
  logic [15:0] underflow_cnt;
  logic [15:0] frame_cnt;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned pop_idx, nreq, nreq_total;
  int          ws_cfg, lat_cfg, cur_beat;
  bit          gap_en, agent_busy;

  vga_burst_reader #(
    .HDISP     (HDISP),
    .VDISP     (VDISP),
    .BURST     (BURST),
    .FIFO_DEPTH(FIFO_DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_burstcount   (avm_burstcount),
    .avm_byteenable   (avm_byteenable),
    .avm_readdata     (avm_readdata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .frame_start      (frame_start),
    .pix_data         (pix_data),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .underflow        (underflow)
`ifdef VGA_READER_STATS_EN
    ,
    .underflow_cnt    (underflow_cnt),
    .frame_cnt        (frame_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a scrambled function of the byte address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic agent_tick(output bit ab);
    @(posedge clk);
    #1;
    ab = !reset_n;
  endtask

  task automatic agent_abort();
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    agent_busy        = 1'b0;
    cur_beat          = 0;
  endtask

  task automatic serve_burst();
    logic [31:0] a0;
    bit          ab;
    int          g;
    a0         = avm_address;
    agent_busy = 1'b1;
    cur_beat   = 0;
    chk("req_burstcount", 32'(avm_burstcount), BURST);
    if (ws_cfg > 0) avm_waitrequest = 1'b1;
    for (int k = 0; k < ws_cfg; k++) begin
      agent_tick(ab);
      if (ab) begin agent_abort(); return; end
      chk("stall_read", 32'(avm_read), 32'd1);
      chk("stall_addr", avm_address, a0);
      chk("stall_burstcount", 32'(avm_burstcount), BURST);
    end
    avm_waitrequest = 1'b0;
    agent_tick(ab);
    if (ab) begin agent_abort(); return; end
    chk("req_addr", a0, BASE + 32'(4 * BURST * (nreq % FRAME_BURSTS)));
    nreq++;
    nreq_total++;
    for (int k = 0; k < lat_cfg - 1; k++) begin
      agent_tick(ab);
      if (ab) begin agent_abort(); return; end
    end
    for (int b = 0; b < int'(BURST); b++) begin
      g = gap_en ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < g; k++) begin
        agent_tick(ab);
        if (ab) begin agent_abort(); return; end
      end
      avm_readdatavalid = 1'b1;
      avm_readdata      = word_of(a0 + 32'(4 * b));
      agent_tick(ab);
      avm_readdatavalid = 1'b0;
      if (ab) begin agent_abort(); return; end
      cur_beat = b + 1;
    end
    agent_busy = 1'b0;
  endtask

  initial begin : agent
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    agent_busy        = 1'b0;
    cur_beat          = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && avm_read) serve_burst();
    end
  end

  // Pixel scoreboard: the n-th pop since reset/frame_start must be frame word n mod frame size.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_n && pix_valid && pix_ready && !frame_start) begin
        chk("pix_data", pix_data, word_of(BASE + 32'(4 * (pop_idx % FRAME_WORDS))));
        pop_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_pops(input int unsigned n, input int maxc);
    int c = 0;
    while (pop_idx < n && c < maxc) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      tick();
      c++;
    end
    pix_ready = 1'b0;
    chk("pops_done", 32'(pop_idx >= n), 32'd1);
  endtask

  task automatic wait_beat(input int target, input int maxc);
    int c = 0;
    while (!(agent_busy && cur_beat == target) && c < maxc) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      tick();
      c++;
    end
    chk("beat_wait", 32'(agent_busy && cur_beat == target), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_addr"}, avm_address, BASE);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_data"}, pix_data, 32'd0);
    chk({tag, "_underflow"}, 32'(underflow), 32'd0);
`ifdef VGA_READER_STATS_EN
    chk({tag, "_underflow_cnt"}, 32'(underflow_cnt), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
`endif
  endtask

  initial begin : stimulus
    int c;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    pix_ready   = 1'b0;
    ws_cfg      = 0;
    lat_cfg     = 4;
    gap_en      = 1'b0;
    pop_idx     = 0;
    nreq        = 0;
    nreq_total  = 0;
    #1;
    check_reset_values("reset");
    chk("byteenable", 32'(avm_byteenable), 32'hF);
    chk("burstcount", 32'(avm_burstcount), BURST);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Three pops against an empty FIFO.
    pix_ready = 1'b1;
    repeat (3) tick();
    pix_ready = 1'b0;
    chk("underflow_set", 32'(underflow), 32'd1);
    chk("empty_after_reset", 32'(pix_valid), 32'd0);
`ifdef VGA_READER_STATS_EN
    chk("underflow_cnt", 32'(underflow_cnt), 32'd3);
`endif

    // Fill with no consumer: exactly four bursts fit.
    repeat (200) tick();
    chk("fill_bursts", nreq_total, 32'd4);
    chk("fill_no_read", 32'(avm_read), 32'd0);
    chk("fill_valid", 32'(pix_valid), 32'd1);
    chk("fill_head", pix_data, word_of(BASE));
    chk("underflow_sticky", 32'(underflow), 32'd1);

    // Long waitrequest stalls while streaming past the frame wrap.
    ws_cfg = 7;
    run_pops(160, 4000);
    chk("wrap_reached", 32'(nreq_total >= FRAME_BURSTS + 1), 32'd1);

    // frame_start after beat 5 of a burst.
    ws_cfg = 2;
    gap_en = 1'b1;
    wait_beat(6, 2000);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pop_idx     = 0;
    nreq        = 0;
    pix_ready   = 1'b0;
    chk("fs_flush", 32'(pix_valid), 32'd0);
    c = 0;
    while (agent_busy && c < 200) begin tick(); c++; end
    chk("fs_burst_end", 32'(agent_busy), 32'd0);
    chk("fs_discard", 32'(pix_valid), 32'd0);
    c = 0;
    while (!pix_valid && c < 200) begin tick(); c++; end
    chk("fs_refill", 32'(pix_valid), 32'd1);
    chk("fs_first_word", pix_data, word_of(BASE));
    run_pops(48, 2000);

    // Asynchronous reset in the middle of a burst.
    wait_beat(3, 2000);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    pop_idx = 0;
    nreq    = 0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    gap_en  = 1'b0;
    run_pops(32, 2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
